framebuffer_write: RTL and testbench

- Write-side counterpart of the panel framebuffer fetch path: consumes a byte stream of RGB565 pixel data and writes it into the write port of the dual-port framebuffer RAM.
- Uses the same address map the display fetch logic reads: {half, row[3:0], ~column[5:0]}.
- Sits between the byte receiver (UART/SPI deframer) and the framebuffer RAM.
- Tracks frame position, assembles 16-bit pixels from byte pairs, and reports frame completion.

---
 rtl/framebuffer_write.sv | 97 +++++++++
 tb/tb_framebuffer_write.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_write.sv
// Byte-stream to framebuffer write port: pairs bytes into RGB565 pixels and
// writes them in stream order using the display's {half, row, ~column} map.
module framebuffer_write #(
  parameter int COLUMN_BITS     = 6,
  parameter int ROW_BITS        = 4,
  parameter bit HIGH_BYTE_FIRST = 1'b1
) (
  input  logic                            clk_in,
  input  logic                            reset,
  input  logic                            frame_start,
  input  logic [7:0]                      data_in,
  input  logic                            data_valid,
  output logic [ROW_BITS+COLUMN_BITS:0]   ram_address,
  output logic [15:0]                     ram_data_out,
  output logic                            ram_write_enable,
  output logic                            ram_clk_enable,
  output logic [ROW_BITS+COLUMN_BITS:0]   pixel_count,
  output logic                            frame_done
);

  localparam int AW = 1 + ROW_BITS + COLUMN_BITS;
  localparam logic [AW-1:0] PIXEL_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_t;

  phase_t        r_phase;
  logic [7:0]    r_held;
  logic [AW-1:0] r_pixel;
  logic [AW-1:0] r_address;
  logic [15:0]   r_data;
  logic          r_write_enable;
  logic          r_frame_done;

  logic [15:0]   w_pixel;
  logic [AW-1:0] w_address;
  logic          w_last_pixel;

  assign w_pixel      = HIGH_BYTE_FIRST ? {r_held, data_in} : {data_in, r_held};
  // The fetch side scans columns right-to-left, hence the inverted column field.
  assign w_address    = {r_pixel[AW-1:COLUMN_BITS], ~r_pixel[COLUMN_BITS-1:0]};
  assign w_last_pixel = &r_pixel;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_phase        <= PH_FIRST;
      r_held         <= 8'h00;
      r_pixel        <= '0;
      r_address      <= '0;
      r_data         <= 16'h0000;
      r_write_enable <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_write_enable <= 1'b0;
      r_frame_done   <= 1'b0;
      if (frame_start) begin
        // A byte arriving with frame_start becomes the first byte of pixel 0.
        r_pixel <= '0;
        if (data_valid) begin
          r_held  <= data_in;
          r_phase <= PH_SECOND;
        end else begin
          r_held  <= 8'h00;
          r_phase <= PH_FIRST;
        end
      end else if (data_valid) begin
        case (r_phase)
          PH_FIRST: begin
            r_held  <= data_in;
            r_phase <= PH_SECOND;
          end
          PH_SECOND: begin
            r_data         <= w_pixel;
            r_address      <= w_address;
            r_write_enable <= 1'b1;
            r_frame_done   <= w_last_pixel;
            r_pixel        <= r_pixel + PIXEL_ONE;
            r_phase        <= PH_FIRST;
          end
          default: r_phase <= PH_FIRST;
        endcase
      end
    end
  end

  assign ram_address      = r_address;
  assign ram_data_out     = r_data;
  assign ram_write_enable = r_write_enable;
  assign ram_clk_enable   = r_write_enable;
  assign pixel_count      = r_pixel;
  assign frame_done       = r_frame_done;

endmodule

// File: tb/tb_framebuffer_write.sv
// Bench for framebuffer_write: a stream-level model checked every cycle, plus
// hand-computed expectations for the key scenarios, on both byte orders.
module tb_framebuffer_write;

  logic        clk_in;
  logic        reset;
  logic        frame_start;
  logic [7:0]  data_in;
  logic        data_valid;

  logic [10:0] addr_a, addr_b, count_a, count_b;
  logic [15:0] data_a, data_b;
  logic        we_a, we_b, ce_a, ce_b, done_a, done_b;

  framebuffer_write #(.COLUMN_BITS(6), .ROW_BITS(4), .HIGH_BYTE_FIRST(1'b1)) dut_a (
    .clk_in(clk_in), .reset(reset), .frame_start(frame_start),
    .data_in(data_in), .data_valid(data_valid),
    .ram_address(addr_a), .ram_data_out(data_a), .ram_write_enable(we_a),
    .ram_clk_enable(ce_a), .pixel_count(count_a), .frame_done(done_a)
  );

  framebuffer_write #(.COLUMN_BITS(6), .ROW_BITS(4), .HIGH_BYTE_FIRST(1'b0)) dut_b (
    .clk_in(clk_in), .reset(reset), .frame_start(frame_start),
    .data_in(data_in), .data_valid(data_valid),
    .ram_address(addr_b), .ram_data_out(data_b), .ram_write_enable(we_b),
    .ram_clk_enable(ce_b), .pixel_count(count_b), .frame_done(done_b)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: bytes counted since the last frame_start; pixel = bytes/2.
  function automatic int addr_of(input int idx);
    int half, row, col;
    half = idx / 1024;
    row  = (idx / 64) % 16;
    col  = idx % 64;
    return half * 1024 + row * 64 + (63 - col);
  endfunction

  int          m_bytes;
  logic [7:0]  m_prev;
  logic        e_we, e_done;
  logic [10:0] e_addr, e_count;
  logic [15:0] e_data_a, e_data_b;

  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      m_bytes  = 0;
      m_prev   = 8'h00;
      e_we     = 1'b0;
      e_done   = 1'b0;
      e_addr   = 11'h000;
      e_count  = 11'h000;
      e_data_a = 16'h0000;
      e_data_b = 16'h0000;
    end else begin
      e_we   = 1'b0;
      e_done = 1'b0;
      if (frame_start) begin
        m_bytes = data_valid ? 1 : 0;
        m_prev  = data_in;
      end else if (data_valid) begin
        if (m_bytes % 2 == 1) begin
          int idx;
          idx      = (m_bytes / 2) % 2048;
          e_we     = 1'b1;
          e_done   = (idx == 2047);
          e_addr   = 11'(addr_of(idx));
          e_data_a = {m_prev, data_in};
          e_data_b = {data_in, m_prev};
        end else begin
          m_prev = data_in;
        end
        m_bytes++;
      end
      e_count = 11'((m_bytes / 2) % 2048);
    end
  end

  logic prev_we = 1'b0;

  always @(posedge clk_in) begin
    #1;
    if (!reset) begin
      check("we_a",    32'(we_a),    32'(e_we));
      check("we_b",    32'(we_b),    32'(e_we));
      check("ce_a",    32'(ce_a),    32'(e_we));
      check("ce_b",    32'(ce_b),    32'(e_we));
      check("addr_a",  32'(addr_a),  32'(e_addr));
      check("addr_b",  32'(addr_b),  32'(e_addr));
      check("data_a",  32'(data_a),  32'(e_data_a));
      check("data_b",  32'(data_b),  32'(e_data_b));
      check("count_a", 32'(count_a), 32'(e_count));
      check("count_b", 32'(count_b), 32'(e_count));
      check("done_a",  32'(done_a),  32'(e_done));
      check("done_b",  32'(done_b),  32'(e_done));
      check("we_back_to_back", 32'(prev_we & we_a), 32'(0));
      prev_we = we_a;
    end else begin
      prev_we = 1'b0;
    end
  end

  // Drive one cycle of inputs at a negedge; return at the next negedge so the
  // outputs produced by that cycle can be checked immediately.
  task automatic cyc(input logic v, input logic [7:0] b, input logic fs);
    data_valid  = v;
    data_in     = b;
    frame_start = fs;
    @(negedge clk_in);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(we_a),    32'(0));
    check({tag, "_ce"},    32'(ce_a),    32'(0));
    check({tag, "_addr"},  32'(addr_a),  32'(0));
    check({tag, "_data"},  32'(data_a),  32'(0));
    check({tag, "_datab"}, 32'(data_b),  32'(0));
    check({tag, "_count"}, 32'(count_a), 32'(0));
    check({tag, "_done"},  32'(done_a),  32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] v;
    reset       = 1'b1;
    frame_start = 1'b0;
    data_valid  = 1'b0;
    data_in     = 8'h00;
    repeat (2) @(negedge clk_in);
    check_all_zero("reset");
    reset = 1'b0;

    // First pixel after reset.
    cyc(1'b1, 8'hF8, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    check("p0_we",    32'(we_a),    32'h1);
    check("p0_ce",    32'(ce_a),    32'h1);
    check("p0_data",  32'(data_a),  32'hF800);
    check("p0_datab", 32'(data_b),  32'h00F8);
    check("p0_addr",  32'(addr_a),  32'h03F);
    check("p0_count", 32'(count_a), 32'h1);
    cyc(1'b0, 8'h00, 1'b0);
    check("p0_idle_we",   32'(we_a),   32'h0);
    check("p0_hold_addr", 32'(addr_a), 32'h03F);
    check("p0_hold_data", 32'(data_a), 32'hF800);

    // Low-byte-first order.
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'hF8, 1'b0);
    check("p1_datab", 32'(data_b),  32'hF800);
    check("p1_data",  32'(data_a),  32'h00F8);
    check("p1_addr",  32'(addr_a),  32'h03E);
    check("p1_count", 32'(count_a), 32'h2);

    // One row of 64 pixels, then the first pixel of row 1.
    cyc(1'b0, 8'h00, 1'b1);
    check("fs_count", 32'(count_a), 32'h0);
    for (int i = 0; i < 64; i++) begin
      cyc(1'b1, 8'h00, 1'b0);
      cyc(1'b1, 8'(i), 1'b0);
    end
    check("row0_last_addr",  32'(addr_a),  32'h000);
    check("row0_last_data",  32'(data_a),  32'h003F);
    check("row0_last_count", 32'(count_a), 32'd64);
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'h40, 1'b0);
    check("row1_first_addr",  32'(addr_a),  32'h07F);
    check("row1_first_data",  32'(data_a),  32'h0040);
    check("row1_first_count", 32'(count_a), 32'd65);

    // Full frame of 2048 pixels, back to back.
    cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 2048; i++) begin
      v = 16'(i * 37 + 5);
      cyc(1'b1, v[15:8], 1'b0);
      cyc(1'b1, v[7:0], 1'b0);
    end
    check("frame_last_we",    32'(we_a),    32'h1);
    check("frame_last_done",  32'(done_a),  32'h1);
    check("frame_last_addr",  32'(addr_a),  32'h7C0);
    check("frame_last_count", 32'(count_a), 32'h0);
    check("frame_last_data",  32'(data_a),  32'(16'(2047 * 37 + 5)));
    cyc(1'b0, 8'h00, 1'b0);
    check("frame_done_drop", 32'(done_a), 32'h0);
    cyc(1'b1, 8'hAB, 1'b0);
    cyc(1'b1, 8'hCD, 1'b0);
    check("wrap_addr",  32'(addr_a),  32'h03F);
    check("wrap_data",  32'(data_a),  32'hABCD);
    check("wrap_count", 32'(count_a), 32'h1);
    check("wrap_done",  32'(done_a),  32'h0);

    // frame_start with a byte discards the held 0xAA.
    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 8'h12, 1'b1);
    check("fs_byte_we",    32'(we_a),    32'h0);
    check("fs_byte_count", 32'(count_a), 32'h0);
    cyc(1'b1, 8'h34, 1'b0);
    check("fs_pair_we",    32'(we_a),    32'h1);
    check("fs_pair_data",  32'(data_a),  32'h1234);
    check("fs_pair_addr",  32'(addr_a),  32'h03F);
    check("fs_pair_count", 32'(count_a), 32'h1);

    // Reset between the two bytes of pixel 5.
    cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'h10, 1'b0);
      cyc(1'b1, 8'(i), 1'b0);
    end
    cyc(1'b1, 8'h55, 1'b0);
    check("pre_reset_count", 32'(count_a), 32'h5);
    data_valid = 1'b0;
    reset      = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk_in);
    reset = 1'b0;
    cyc(1'b1, 8'h9A, 1'b0);
    cyc(1'b1, 8'hBC, 1'b0);
    check("post_reset_addr",  32'(addr_a),  32'h03F);
    check("post_reset_data",  32'(data_a),  32'h9ABC);
    check("post_reset_count", 32'(count_a), 32'h1);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
